// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: starts the MULT/DIV unit, waits for its stop flag, writes HI/LO
// and reports done, divide-by-zero or watchdog timeout back to main control.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic op_mult,
  input  logic op_div,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  output logic ctrl_mult,
  output logic ctrl_div,
  output logic ctrl_hilo,
  output logic hilo_write,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout
);
  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, WRITE, FIN, EXC, TOUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic run, expired, hilo_d;
  assign {ctrl_mult, ctrl_div, ctrl_hilo, hilo_write, busy, done, div_zero_exc, timeout} = out_q;
  always_comb begin
    run = state_q == MULT_RUN || state_q == DIV_RUN;
    expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    cnt_d = run ? cnt_q + CNT_W'(1) : '0;
    state_d = state_q;
    hilo_d = out_q[5];
    case (state_q)
      IDLE: begin
        state_d = op_mult ? MULT_RUN : op_div ? DIV_RUN : IDLE;
        hilo_d = op_mult ? 1'b0 : op_div ? 1'b1 : out_q[5];
      end
      MULT_RUN: state_d = mult_stop ? WRITE : expired ? TOUT : MULT_RUN;
      DIV_RUN:  state_d = div_zero ? EXC : div_stop ? WRITE : expired ? TOUT : DIV_RUN;
      WRITE:    state_d = FIN;
      default:  state_d = IDLE;
    endcase
    // Outputs are a function of the next state so they appear registered in that state's cycle
    out_d = {state_q == IDLE && state_d == MULT_RUN, state_q == IDLE && state_d == DIV_RUN,
             hilo_d, state_d == WRITE, state_d != IDLE, state_d == FIN, state_d == EXC,
             state_d == TOUT};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table vectors, directed multi-cycle sequences and random
// stimulus checked against a transaction-level model of the sequencer.
module tb_muldiv_sequencer;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic reset, op_mult, op_div, mult_stop, div_stop, div_zero;
  logic ctrl_mult, ctrl_div, ctrl_hilo, hilo_write, busy, done, div_zero_exc, timeout;
  logic [7:0] outs, got;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_mult(op_mult), .op_div(op_div),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .ctrl_hilo(ctrl_hilo),
    .hilo_write(hilo_write), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout(timeout)
  );
  assign outs = {ctrl_mult, ctrl_div, ctrl_hilo, hilo_write, busy, done, div_zero_exc, timeout};

  // Model: an operation in flight, plus a queue of the pulses that follow its end
  logic m_run = 1'b0, m_kind = 1'b0, m_hilo = 1'b0;
  int m_runs = 0;
  logic [7:0] m_exp = '0;
  logic [7:0] m_tail[$];

  function automatic logic [7:0] mk(logic cm, logic cd, logic hw, logic bz, logic dn, logic ex, logic to);
    return {cm, cd, m_hilo, hw, bz, dn, ex, to};
  endfunction

  task automatic model_step(input logic r, om, od, ms, ds, dz);
    if (r) begin
      m_run = 1'b0;
      m_tail.delete();
      m_hilo = 1'b0;
      m_exp = '0;
    end else if (m_run) begin
      if (m_kind && dz) m_tail = {mk(0, 0, 0, 1, 0, 1, 0)};
      else if (m_kind ? ds : ms) m_tail = {mk(0, 0, 1, 1, 0, 0, 0), mk(0, 0, 0, 1, 1, 0, 0)};
      else if (m_runs == TO - 1) m_tail = {mk(0, 0, 0, 1, 0, 0, 1)};
      if (m_tail.size() != 0) begin
        m_run = 1'b0;
        m_exp = m_tail.pop_front();
      end else begin
        m_runs++;
        m_exp = mk(0, 0, 0, 1, 0, 0, 0);
      end
    end else if (m_exp[3]) begin
      m_exp = (m_tail.size() != 0) ? m_tail.pop_front() : mk(0, 0, 0, 0, 0, 0, 0);
    end else if (om || od) begin
      m_run = 1'b1;
      m_kind = !om;
      m_hilo = !om;
      m_runs = 0;
      m_exp = mk(om, !om, 0, 1, 0, 0, 0);
    end else begin
      m_exp = mk(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, sample at the next falling edge
  task automatic tick(input logic r, om, od, ms, ds, dz);
    reset = r; op_mult = om; op_div = od; mult_stop = ms; div_stop = ds; div_zero = dz;
    @(posedge clk);
    model_step(r, om, od, ms, ds, dz);
    @(negedge clk);
    got = outs;
    check("model", int'(got), int'(m_exp));
  endtask

  typedef struct {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int cm_n, cd_n, hw_n, to_n, dn_n, ex_n, hw_at, dn_at, to_at, idle_at;
    logic [5:0] v;
    reset = 1'b1; op_mult = 0; op_div = 0; mult_stop = 0; div_stop = 0; div_zero = 0;
    @(negedge clk);
    // in = {reset, op_mult, op_div, mult_stop, div_stop, div_zero}
    // exp = {ctrl_mult, ctrl_div, ctrl_hilo, hilo_write, busy, done, div_zero_exc, timeout}
    tbl.push_back('{6'b100000, 8'b00000000});
    tbl.push_back('{6'b000000, 8'b00000000});
    tbl.push_back('{6'b010000, 8'b10001000});
    tbl.push_back('{6'b000100, 8'b00011000});
    tbl.push_back('{6'b000000, 8'b00001100});
    tbl.push_back('{6'b000000, 8'b00000000});
    tbl.push_back('{6'b001000, 8'b01101000});
    tbl.push_back('{6'b000011, 8'b00101010});
    tbl.push_back('{6'b000000, 8'b00100000});
    tbl.push_back('{6'b001000, 8'b01101000});
    tbl.push_back('{6'b000010, 8'b00111000});
    tbl.push_back('{6'b010000, 8'b00101100});
    tbl.push_back('{6'b010000, 8'b00100000});
    tbl.push_back('{6'b011000, 8'b10001000});
    tbl.push_back('{6'b000011, 8'b00001000});
    tbl.push_back('{6'b000100, 8'b00011000});
    tbl.push_back('{6'b001000, 8'b00001100});
    tbl.push_back('{6'b001000, 8'b00000000});
    tbl.push_back('{6'b001000, 8'b01101000});
    tbl.push_back('{6'b000100, 8'b00101000});
    tbl.push_back('{6'b000001, 8'b00101010});
    tbl.push_back('{6'b010000, 8'b00100000});
    tbl.push_back('{6'b010000, 8'b10001000});
    tbl.push_back('{6'b000100, 8'b00011000});
    tbl.push_back('{6'b000000, 8'b00001100});
    tbl.push_back('{6'b000000, 8'b00000000});
    foreach (tbl[i]) begin
      v = tbl[i].in;
      tick(v[5], v[4], v[3], v[2], v[1], v[0]);
      check($sformatf("table[%0d]", i), int'(got), int'(tbl[i].exp));
    end

    // MULT with stop 33 cycles after the start pulse
    cm_n = 0; hw_at = -1; dn_at = -1; idle_at = -1;
    tick(0, 1, 0, 0, 0, 0);
    cm_n += int'(got[7]);
    check("mult33_hilo", int'(got[5]), 0);
    for (int j = 1; j <= 36; j++) begin
      tick(0, 0, 0, j == 34, 0, 0);
      cm_n += int'(got[7]);
      if (got[4]) hw_at = j;
      if (got[2]) dn_at = j;
      if (!got[3] && idle_at < 0) idle_at = j;
    end
    check("mult33_start_pulses", cm_n, 1);
    check("mult33_write_cycle", hw_at, 34);
    check("mult33_done_cycle", dn_at, 35);
    check("mult33_idle_cycle", idle_at, 36);

    // DIV with stop after 5 cycles, then MULT accepted in the first IDLE cycle
    tick(0, 0, 1, 0, 0, 0);
    check("div5_start", int'(got), 8'b01101000);
    for (int j = 1; j <= 10; j++) begin
      tick(0, j == 9, 0, 0, j == 6, 0);
      if (j == 6) check("div5_write", int'(got), 8'b00111000);
      if (j == 7) check("div5_done", int'(got), 8'b00101100);
      if (j == 8) check("div5_idle", int'(got), 8'b00100000);
      if (j == 9) check("b2b_mult_start", int'(got), 8'b10001000);
    end
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Watchdog: MULT with no stop, op_div issued mid-run
    to_n = 0; to_at = -1; hw_n = 0; cd_n = 0;
    tick(0, 1, 0, 0, 0, 0);
    for (int j = 1; j <= 42; j++) begin
      tick(0, 0, j == 20, 0, 0, 0);
      to_n += int'(got[0]);
      hw_n += int'(got[4]);
      cd_n += int'(got[6]);
      if (got[0]) to_at = j;
    end
    check("tout_pulses", to_n, 1);
    check("tout_cycle", to_at, TO);
    check("tout_no_write", hw_n, 0);
    check("tout_div_ignored", cd_n, 0);

    // Async reset mid DIV_RUN, then a normal DIV
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check("async_reset_outs", int'(outs), 0);
    model_step(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    check("post_reset_div_start", int'(got), 8'b01101000);
    hw_n = 0; dn_n = 0; ex_n = 0;
    for (int j = 1; j <= 6; j++) begin
      tick(0, 0, 0, 0, j == 3, 0);
      hw_n += int'(got[4]);
      dn_n += int'(got[2]);
      ex_n += int'(got[1]);
    end
    check("post_reset_div_write", hw_n, 1);
    check("post_reset_div_done", dn_n, 1);
    check("post_reset_div_no_exc", ex_n, 0);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      if (int'(got[2]) + int'(got[1]) + int'(got[0]) > 1 || (got[4] && (got[1] || got[0])))
        check("exclusive_pulses", int'(got), int'(m_exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Sequences the iterative MULT and DIV units and the shared HI/LO register pair on behalf of the main multi-cycle control FSM. Main control issues a one-cycle start request and stalls on busy. This block pulses the unit start, waits for the unit's stop flag, selects the HI/LO mux source and writes HI/LO. It reports completion, divide-by-zero or watchdog timeout back to control, which uses them for exception entry.

Parameters:
TIMEOUT_CYCLES, 40, maximum run-state cycles before watchdog abort; legal range 2..63
CNT_W, 6, width of the run-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op_mult  input  1  one-cycle request from control: start MULT
op_div  input  1  one-cycle request from control: start DIV
mult_stop  input  1  MULT unit finished; result valid on MULT HI/LO outputs
div_stop  input  1  DIV unit finished; result valid on DIV HI/LO outputs
div_zero  input  1  DIV unit detected divisor == 0
ctrl_mult  output  1  start pulse to MULT unit
ctrl_div  output  1  start pulse to DIV unit
ctrl_hilo  output  1  HI/LO source mux select: 0 = MULT, 1 = DIV
hilo_write  output  1  write enable for the HI and LO registers
busy  output  1  operation in progress; control must hold in its wait state
done  output  1  one-cycle pulse: operation retired, HI/LO updated
div_zero_exc  output  1  one-cycle pulse: division by zero; HI/LO not written
timeout  output  1  one-cycle pulse: watchdog expired; HI/LO not written

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Outputs: all outputs are registered (Moore). No combinational path from any input to any output.
- Reset values: state = IDLE, counter = 0, and every output = 0, including ctrl_hilo.
- Reset mid-operation: returns to IDLE immediately. No hilo_write, done or exception pulse is produced.
- States: IDLE, MULT_RUN, DIV_RUN, WRITE, FIN, EXC, TOUT.
- IDLE: busy = 0.
  - op_mult = 1 → MULT_RUN; ctrl_hilo <= 0.
  - Else op_div = 1 → DIV_RUN; ctrl_hilo <= 1.
  - Both high in the same cycle → MULT wins; the div request is dropped with no error.
- Requests while busy = 1 are ignored.
- Run-state entry: first cycle of MULT_RUN/DIV_RUN drives ctrl_mult/ctrl_div = 1 for exactly one cycle. busy = 1 from that cycle until return to IDLE. Counter clears to 0 on entry and increments every run cycle.
- MULT_RUN:
  - mult_stop = 1 → WRITE.
  - Else counter == TIMEOUT_CYCLES-1 → TOUT.
  - div_stop and div_zero are ignored.
- DIV_RUN:
  - div_zero = 1 → EXC. div_zero has priority over a simultaneous div_stop.
  - Else div_stop = 1 → WRITE.
  - Else counter == TIMEOUT_CYCLES-1 → TOUT.
  - mult_stop is ignored.
- Stop flags are honoured from the first run cycle, including the start-pulse cycle.
- WRITE: hilo_write = 1 for one cycle; ctrl_hilo held. Next state is FIN.
- FIN: done = 1 for one cycle; busy = 1. Next state is IDLE.
- EXC: div_zero_exc = 1 for one cycle; hilo_write stays 0. Next state is IDLE.
- TOUT: timeout = 1 for one cycle; hilo_write stays 0. Next state is IDLE.
- ctrl_hilo: holds its last value in IDLE. Changes only on request acceptance.
- Latency: request accepted at edge T → start pulse in cycle T+1. Stop seen in cycle S → hilo_write in S+1, done in S+2, IDLE in S+3. Minimum request-to-done is 3 cycles.
- Back-to-back: a new request is accepted in the first IDLE cycle after FIN, EXC or TOUT.
- Exclusivity: at most one of done, div_zero_exc, timeout is high in any cycle. hilo_write is never high together with div_zero_exc or timeout.

Test Plan:
- Reset, then op_mult for 1 cycle; mult_stop asserted 33 cycles after ctrl_mult → ctrl_mult high exactly 1 cycle, ctrl_hilo = 0, hilo_write 1 cycle after the stop, done 1 cycle later, busy low on the following cycle.
- op_div; div_stop after 5 cycles → ctrl_div 1 cycle, ctrl_hilo = 1 through WRITE, hilo_write then done. Repeat immediately with op_mult: accepted in the first IDLE cycle and ctrl_hilo returns to 0.
- op_div with div_zero and div_stop both asserted in the same cycle → div_zero_exc pulse only; hilo_write = 0 and done = 0 throughout.
- op_mult with no mult_stop, TIMEOUT_CYCLES = 40 → timeout pulses once after 40 run cycles; no hilo_write; op_div issued mid-run is ignored.
- op_mult and op_div asserted together → MULT path only (ctrl_div never asserted). A spurious div_stop during MULT_RUN does not end the operation.
- Assert reset asynchronously mid-DIV_RUN → all outputs 0 before the next clock edge. After release, a new op_div completes normally.
